zcash_verif_hdr_arb: RTL and testbench

- N-channel header arbiter in front of a single zcash_verif_equihash instance.
- Accepts block-header AXI streams on N_CH independent input channels and grants whole packets round-robin to one output stream.
- Records the granting channel of each packet in an in-order tag FIFO.
- Routes each returned verifier mask back to the originating channel. Lets several header sources (PCIe, UART, test replay) share one verifier.

---
 rtl/zcash_verif_hdr_arb.sv | 195 +++++++++++++++++++
 tb/tb_zcash_verif_hdr_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zcash_verif_hdr_arb.sv
// Header arbiter: N_CH block-header streams share one equihash verifier.
// Whole packets are granted round-robin, the granting channel is queued in
// an in-order tag FIFO, and each returned verifier mask is routed back to
// the channel that sent the matching packet.
module zcash_verif_hdr_arb #(
  parameter int N_CH      = 4,
  parameter int DAT_BYTS  = 8,
  parameter int MOD_BITS  = 3,
  parameter int MASK_W    = 8,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_CH-1:0]              i_val,
  input  logic [N_CH-1:0]              i_sop,
  input  logic [N_CH-1:0]              i_eop,
  input  logic [N_CH*MOD_BITS-1:0]     i_mod,
  input  logic [N_CH*DAT_BYTS*8-1:0]   i_dat,
  output logic [N_CH-1:0]              o_rdy,
  output logic                         o_val,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic [MOD_BITS-1:0]          o_mod,
  output logic [DAT_BYTS*8-1:0]        o_dat,
  input  logic                         i_rdy,
  input  logic [MASK_W-1:0]            i_mask,
  input  logic                         i_mask_val,
  output logic [MASK_W-1:0]            o_mask,
  output logic [N_CH-1:0]              o_mask_val,
  output logic [15:0]                  o_drop_cnt,
  output logic                         o_err
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam int INC_W = $clog2(N_CH + 1);
  localparam int DW    = DAT_BYTS * 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]      state;
  logic [CH_W-1:0] rr;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] grant_inc;

  logic [CH_W-1:0]  tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] tag_cnt;
  logic             tag_full;
  logic             tag_empty;
  logic [CH_W-1:0]  tag_head;

  logic [N_CH-1:0]  cand;
  logic [N_CH-1:0]  orphan;
  logic             pick_found;
  logic [CH_W-1:0]  pick_idx;
  logic             push;
  logic             pop;
  logic             pkt_done;
  logic [INC_W-1:0] drop_inc;
  logic [16:0]      drop_sum;

  assign tag_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[rd_ptr];
  assign cand      = i_val & i_sop;
  assign grant_inc = (grant == CH_W'(N_CH - 1)) ? '0 : grant + 1'b1;

  // A result pops the head only if there is one; a grant may reuse the slot
  // freed by a same-cycle pop, so a full FIFO does not block it then.
  assign pop      = i_mask_val & ~tag_empty;
  assign push     = (state == ST_IDLE) & pick_found & (~tag_full | pop);
  assign pkt_done = (state == ST_LOCK) & o_val & i_rdy & o_eop;

  // Orphan words are only swallowed while idle and out of reset
  assign orphan = (i_rst_n && state == ST_IDLE) ? (i_val & ~i_sop) : '0;

  // Round-robin search: first sop candidate at or after the rr pointer
  always_comb begin
    int idx;
    logic [CH_W-1:0] idx_b;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    idx_b      = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_b = CH_W'(idx);
      if (!pick_found && cand[idx_b]) begin
        pick_found = 1'b1;
        pick_idx   = idx_b;
      end
    end
  end

  // Output mux: mirror the granted channel while locked; all quiet in reset
  always_comb begin
    o_val = 1'b0;
    o_sop = 1'b0;
    o_eop = 1'b0;
    o_mod = '0;
    o_dat = '0;
    o_rdy = '0;
    if (i_rst_n) begin
      if (state == ST_LOCK) begin
        o_val        = i_val[grant];
        o_sop        = i_sop[grant];
        o_eop        = i_eop[grant];
        o_mod        = i_mod[grant*MOD_BITS +: MOD_BITS];
        o_dat        = i_dat[grant*DW +: DW];
        o_rdy[grant] = i_rdy;
      end else begin
        o_rdy = orphan;
      end
    end
  end

  // Count orphan words discarded this cycle
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < N_CH; i++) begin
      drop_inc = drop_inc + INC_W'(orphan[i]);
    end
    drop_sum = {1'b0, o_drop_cnt} + 17'(drop_inc);
  end

  // FSM, registered grant and round-robin pointer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      rr    <= '0;
      grant <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (push) begin
            grant <= pick_idx;
            state <= ST_LOCK;
          end
        end
        default: begin
          if (pkt_done) begin
            state <= ST_IDLE;
            rr    <= grant_inc;
          end
        end
      endcase
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Tag storage; contents are meaningless while the pointers say empty
  always_ff @(posedge i_clk) begin
    if (push) tag_mem[wr_ptr] <= pick_idx;
  end

  // Result routing, sticky underflow error and saturating drop counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mask     <= '0;
      o_mask_val <= '0;
      o_drop_cnt <= '0;
      o_err      <= 1'b0;
    end else begin
      o_mask_val <= '0;
      if (pop) begin
        o_mask     <= i_mask;
        o_mask_val <= {{(N_CH-1){1'b0}}, 1'b1} << tag_head;
      end
      if (i_mask_val && tag_empty) o_err <= 1'b1;
      o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_zcash_verif_hdr_arb.sv
// Directed bench for zcash_verif_hdr_arb: per-channel packet sources,
// expected words and result strobes queued at stimulus time and compared
// as the DUT produces them.
module tb_zcash_verif_hdr_arb;
  localparam int N_CH = 4;
  localparam int DAT_BYTS = 8;
  localparam int MOD_BITS = 3;
  localparam int MASK_W = 8;
  localparam int TAG_DEPTH = 4;
  localparam int DW = 64;

  logic                       i_clk = 1'b0;
  logic                       i_rst_n = 1'b1;
  logic [N_CH-1:0]            i_val = '0;
  logic [N_CH-1:0]            i_sop = '0;
  logic [N_CH-1:0]            i_eop = '0;
  logic [N_CH*MOD_BITS-1:0]   i_mod = '0;
  logic [N_CH*DW-1:0]         i_dat = '0;
  logic [N_CH-1:0]            o_rdy;
  logic                       o_val, o_sop, o_eop;
  logic [MOD_BITS-1:0]        o_mod;
  logic [DW-1:0]              o_dat;
  logic                       i_rdy = 1'b1;
  logic [MASK_W-1:0]          i_mask = '0;
  logic                       i_mask_val = 1'b0;
  logic [MASK_W-1:0]          o_mask;
  logic [N_CH-1:0]            o_mask_val;
  logic [15:0]                o_drop_cnt;
  logic                       o_err;

  zcash_verif_hdr_arb #(
    .N_CH(N_CH), .DAT_BYTS(DAT_BYTS), .MOD_BITS(MOD_BITS),
    .MASK_W(MASK_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_mod(i_mod), .i_dat(i_dat),
    .o_rdy(o_rdy), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop),
    .o_mod(o_mod), .o_dat(o_dat), .i_rdy(i_rdy),
    .i_mask(i_mask), .i_mask_val(i_mask_val),
    .o_mask(o_mask), .o_mask_val(o_mask_val),
    .o_drop_cnt(o_drop_cnt), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail = 0;

  logic [68:0]          exp_words[$];
  logic [N_CH+MASK_W-1:0] exp_mask[$];

  int src_rem[N_CH];
  int src_idx[N_CH];
  int src_len[N_CH];
  int src_npkt[N_CH];
  int src_pid[N_CH];
  bit src_orph[N_CH];
  bit rdy_rand = 1'b0;

  function automatic logic [DW-1:0] word_of(int ch, int pid, int idx);
    return {32'(ch), 16'(pid), 16'(idx)};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int ch = 0; ch < N_CH; ch++) begin
      i_val[ch] = (src_rem[ch] > 0);
      i_sop[ch] = (src_rem[ch] > 0) && !src_orph[ch] && (src_idx[ch] == 0);
      i_eop[ch] = (src_rem[ch] > 0) && !src_orph[ch] && (src_rem[ch] == 1);
      i_mod[ch*MOD_BITS +: MOD_BITS] = 3'(src_idx[ch]);
      i_dat[ch*DW +: DW] = word_of(ch, src_pid[ch], src_idx[ch]);
    end
    i_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_src(int ch, int len, int npkt, int pid, bit orph);
    src_rem[ch]  = len;
    src_idx[ch]  = 0;
    src_len[ch]  = len;
    src_npkt[ch] = npkt;
    src_pid[ch]  = pid;
    src_orph[ch] = orph;
    drive_src();
  endtask

  task automatic expect_pkt(int ch, int pid, int len);
    for (int w = 0; w < len; w++) begin
      exp_words.push_back({1'(w == 0), 1'(w == len - 1), 3'(w), word_of(ch, pid, w)});
    end
  endtask

  task automatic clear_src();
    for (int ch = 0; ch < N_CH; ch++) begin
      src_rem[ch] = 0; src_idx[ch] = 0; src_len[ch] = 0;
      src_npkt[ch] = 0; src_pid[ch] = 0; src_orph[ch] = 1'b0;
    end
  endtask

  // One clock: observe at the falling edge, update stimulus 1ns after rising.
  task automatic tick();
    logic [N_CH-1:0] hs;
    logic [68:0] ew;
    logic [N_CH+MASK_W-1:0] em;
    bit mv_due;
    @(negedge i_clk);
    hs = o_rdy & i_val;
    mv_due = i_mask_val;
    if (o_val && i_rdy) begin
      $display("word: sop=%0b eop=%0b mod=%0d dat=%h", o_sop, o_eop, o_mod, o_dat);
      n_assert++;
      assert (exp_words.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word: observed=%h expected=none", o_dat);
      end
      if (exp_words.size() != 0) begin
        ew = exp_words.pop_front();
        check("word_dat", o_dat, ew[63:0]);
        check("word_ctl", {59'd0, o_sop, o_eop, o_mod}, {59'd0, ew[68:64]});
      end
    end
    @(posedge i_clk);
    #1;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (hs[ch]) begin
        src_idx[ch]++;
        src_rem[ch]--;
        if (src_rem[ch] == 0 && src_npkt[ch] > 1) begin
          src_npkt[ch]--;
          src_pid[ch]++;
          src_idx[ch] = 0;
          src_rem[ch] = src_len[ch];
        end
      end
    end
    drive_src();
    if (mv_due && exp_mask.size() != 0) begin
      em = exp_mask.pop_front();
      $display("result: mask_val=%b mask=%h", o_mask_val, o_mask);
      check("mask_val", 64'(o_mask_val), 64'(em[N_CH+MASK_W-1:MASK_W]));
      if (em[N_CH+MASK_W-1:MASK_W] != '0) check("mask", 64'(o_mask), 64'(em[MASK_W-1:0]));
    end else begin
      check("mask_val_idle", 64'(o_mask_val), 64'd0);
    end
  endtask

  task automatic drive_mask(logic [MASK_W-1:0] m, logic [N_CH-1:0] exp_mv);
    i_mask = m;
    i_mask_val = 1'b1;
    exp_mask.push_back({exp_mv, m});
    tick();
    i_mask_val = 1'b0;
  endtask

  task automatic drain(int max_cycles);
    for (int c = 0; c < max_cycles; c++) begin
      if (exp_words.size() == 0) break;
      tick();
    end
    n_assert++;
    assert (exp_words.size() == 0) else begin
      n_fail++;
      $error("FAIL drain_timeout: observed=%0d words left expected=0", exp_words.size());
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    clear_src();
    exp_words.delete();
    exp_mask.delete();
    i_mask_val = 1'b0;
    drive_src();
    #1;
    check("rst_o_val", 64'(o_val), 64'd0);
    check("rst_o_rdy", 64'(o_rdy), 64'd0);
    check("rst_mask_val", 64'(o_mask_val), 64'd0);
    check("rst_mask", 64'(o_mask), 64'd0);
    check("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_src();
    #1;
    do_reset();

    // 1: single 4-word packet on ch2, 1-cycle grant latency, result routed
    rdy_rand = 1'b1;
    start_src(2, 4, 1, 1, 1'b0);
    expect_pkt(2, 1, 4);
    #1;
    check("t1_idle_val", 64'(o_val), 64'd0);
    check("t1_idle_sop_rdy", 64'(o_rdy[2]), 64'd0);
    tick();
    check("t1_sop_to_val", 64'(o_val), 64'd1);
    drain(60);
    rdy_rand = 1'b0;
    drive_mask(8'h00, 4'b0100);
    tick();

    // 2: all channels request from the same cycle -> grants 0,1,2,3
    do_reset();
    rdy_rand = 1'b1;
    for (int ch = 0; ch < N_CH; ch++) start_src(ch, 3, 1, 10 + ch, 1'b0);
    for (int ch = 0; ch < N_CH; ch++) expect_pkt(ch, 10 + ch, 3);
    drain(120);
    rdy_rand = 1'b0;
    drive_mask(8'h11, 4'b0001);
    drive_mask(8'h22, 4'b0010);
    drive_mask(8'h33, 4'b0100);
    drive_mask(8'h44, 4'b1000);
    tick();

    // 3: six packets, results withheld -> four grants, then one per pop
    start_src(0, 2, 2, 20, 1'b0);
    start_src(1, 2, 2, 30, 1'b0);
    start_src(2, 2, 1, 40, 1'b0);
    start_src(3, 2, 1, 50, 1'b0);
    expect_pkt(0, 20, 2);
    expect_pkt(1, 30, 2);
    expect_pkt(2, 40, 2);
    expect_pkt(3, 50, 2);
    drain(80);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("t3_full_no_grant", 64'(o_val), 64'd0);
    end
    expect_pkt(0, 21, 2);
    drive_mask(8'h51, 4'b0001);
    check("t3_grant_with_pop", 64'(o_val), 64'd1);
    drain(20);
    expect_pkt(1, 31, 2);
    drive_mask(8'h52, 4'b0010);
    check("t3_grant_with_pop2", 64'(o_val), 64'd1);
    drain(20);
    drive_mask(8'h53, 4'b0100);
    drive_mask(8'h54, 4'b1000);
    drive_mask(8'h55, 4'b0001);
    drive_mask(8'h56, 4'b0010);
    tick();

    // 4: orphan words on ch1 are swallowed and counted
    start_src(1, 3, 1, 60, 1'b1);
    #1;
    check("t4_orphan_rdy", 64'(o_rdy), 64'(4'b0010));
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t4_no_forward", 64'(o_val), 64'd0);
    end
    check("t4_drop_cnt", 64'(o_drop_cnt), 64'd3);
    start_src(1, 2, 1, 61, 1'b0);
    expect_pkt(1, 61, 2);
    drain(20);
    drive_mask(8'h66, 4'b0010);

    // 5: result with empty tag FIFO -> sticky error, no strobe
    drive_mask(8'h77, 4'b0000);
    check("t5_err", 64'(o_err), 64'd1);
    tick();
    check("t5_err_sticky", 64'(o_err), 64'd1);
    start_src(0, 3, 1, 70, 1'b0);
    expect_pkt(0, 70, 3);
    drain(20);
    drive_mask(8'h88, 4'b0001);
    check("t5_err_still", 64'(o_err), 64'd1);

    // 6: reset on word 2 of a 5-word packet
    start_src(0, 5, 1, 80, 1'b0);
    expect_pkt(0, 80, 5);
    tick();
    tick();
    tick();
    check("t6_mid_packet_val", 64'(o_val), 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_val", 64'(o_val), 64'd0);
    check("t6_rst_rdy", 64'(o_rdy), 64'd0);
    check("t6_rst_drop", 64'(o_drop_cnt), 64'd0);
    check("t6_rst_err", 64'(o_err), 64'd0);
    clear_src();
    exp_words.delete();
    drive_src();
    tick();
    tick();
    i_rst_n = 1'b1;
    start_src(3, 2, 1, 90, 1'b0);
    expect_pkt(3, 90, 2);
    tick();
    check("t6_grant_ch3", 64'(o_val), 64'd1);
    drain(20);
    drive_mask(8'h99, 4'b1000);
    drive_mask(8'hAA, 4'b0000);
    check("t6_fifo_was_empty", 64'(o_err), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
